// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG master: op codes, IEEE 1149.1 TAP state encodings,
// sequence lengths and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RST  = 2'b00,
    OP_IR   = 2'b01,
    OP_DR   = 2'b10,
    OP_IDLE = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    TapExit2Dr = 4'h0,
    TapExit1Dr = 4'h1,
    TapShiftDr = 4'h2,
    TapPauseDr = 4'h3,
    TapSelIr   = 4'h4,
    TapUpdDr   = 4'h5,
    TapCapDr   = 4'h6,
    TapSelDr   = 4'h7,
    TapExit2Ir = 4'h8,
    TapExit1Ir = 4'h9,
    TapShiftIr = 4'hA,
    TapPauseIr = 4'hB,
    TapRti     = 4'hC,
    TapUpdIr   = 4'hD,
    TapCapIr   = 4'hE,
    TapTlr     = 4'hF
  } tap_state_e;

  // tck counts from Run-Test/Idle to the first shift bit, and the leading tms=1 count of a reset.
  localparam int unsigned PRE_LEN_DR  = 3;
  localparam int unsigned PRE_LEN_IR  = 4;
  localparam int unsigned RST_TMS_CNT = 5;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    unique case (s)
      TapTlr:     n = tms ? TapTlr     : TapRti;
      TapRti:     n = tms ? TapSelDr   : TapRti;
      TapSelDr:   n = tms ? TapSelIr   : TapCapDr;
      TapCapDr:   n = tms ? TapExit1Dr : TapShiftDr;
      TapShiftDr: n = tms ? TapExit1Dr : TapShiftDr;
      TapExit1Dr: n = tms ? TapUpdDr   : TapPauseDr;
      TapPauseDr: n = tms ? TapExit2Dr : TapPauseDr;
      TapExit2Dr: n = tms ? TapUpdDr   : TapShiftDr;
      TapUpdDr:   n = tms ? TapSelDr   : TapRti;
      TapSelIr:   n = tms ? TapTlr     : TapCapIr;
      TapCapIr:   n = tms ? TapExit1Ir : TapShiftIr;
      TapShiftIr: n = tms ? TapExit1Ir : TapShiftIr;
      TapExit1Ir: n = tms ? TapUpdIr   : TapPauseIr;
      TapPauseIr: n = tms ? TapExit2Ir : TapPauseIr;
      TapExit2Ir: n = tms ? TapUpdIr   : TapShiftIr;
      TapUpdIr:   n = tms ? TapSelDr   : TapRti;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_master_if.sv
// Host command/response channel of the JTAG master. The host side is the master modport,
// the sequencer is the slave.
interface jtag_master_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output busy
  );

endinterface

// File: rtl/jtag_tck_gen.sv
// TAP clock divider: tck = tclk/2 while enabled, held low otherwise. Strobes mark the tclk
// edge on which tck falls (drive) or rises (sample).
module jtag_tck_gen (
  input  logic tclk,
  input  logic trst,
  input  logic enable,
  output logic tck_o,
  output logic drive_stb,
  output logic sample_stb
);

  logic r_tck;

  always_ff @(posedge tclk) begin
    if (trst) begin
      r_tck <= 1'b0;
    end else if (enable) begin
      r_tck <= ~r_tck;
    end else begin
      r_tck <= 1'b0;
    end
  end

  assign tck_o      = r_tck;
  assign drive_stb  = enable & r_tck & ~trst;
  assign sample_stb = enable & ~r_tck & ~trst;

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG sequencer: turns reset/IR/DR/idle-run commands into TMS/TDI bit
// streams, mirrors the TAP state and returns captured TDO bits.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic              tclk,
  input  logic              trst,
  jtag_master_if.slave      cmd_if,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int unsigned      IDX_W   = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [2:0]       RST_LAST = 3'(RST_TMS_CNT);

  typedef enum logic [2:0] {
    StInitRst,
    StIdle,
    StPre,
    StShift,
    StPost,
    StRun,
    StDone
  } state_e;

  state_e             r_state, w_state_nxt;
  logic [2:0]         r_step, w_step_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]   r_last, w_last_nxt;
  logic [MAX_LEN-1:0] r_data, w_data_nxt;
  logic               r_tms, w_tms_nxt;
  logic               r_tdi, w_tdi_nxt;
  logic               r_is_ir, w_is_ir_nxt;
  logic               r_host, w_host_nxt;
  logic [MAX_LEN-1:0] r_rsp;
  tap_state_e         r_tap_state;

  logic               w_enable, w_drive, w_sample, w_ready, w_accept;
  logic [LEN_W-1:0]   w_scan_last;
  logic [2:0]         w_pre_last, w_pre_ones;
  op_e                w_op;

  jtag_tck_gen u_tck_gen (
    .tclk       (tclk),
    .trst       (trst),
    .enable     (w_enable),
    .tck_o      (tck_o),
    .drive_stb  (w_drive),
    .sample_stb (w_sample)
  );

  assign w_op       = op_e'(cmd_if.cmd_op);
  assign w_enable   = r_state inside {StInitRst, StPre, StShift, StPost, StRun};
  // The mirror check keeps a desynchronised sequencer from taking new work.
  assign w_ready    = (r_state inside {StIdle, StDone}) && (r_tap_state == TapRti);
  assign w_pre_last = r_is_ir ? 3'(PRE_LEN_IR - 1) : 3'(PRE_LEN_DR - 1);
  assign w_pre_ones = r_is_ir ? 3'(PRE_LEN_IR - 2) : 3'(PRE_LEN_DR - 2);

  // Scan length as a last-bit index: 0 behaves as 1, anything above MAX_LEN clamps.
  always_comb begin
    if (cmd_if.cmd_len == '0) begin
      w_scan_last = '0;
    end else if (cmd_if.cmd_len > LEN_MAX) begin
      w_scan_last = LEN_MAX - LEN_W'(1);
    end else begin
      w_scan_last = cmd_if.cmd_len - LEN_W'(1);
    end
  end

  always_ff @(posedge tclk) begin
    if (trst) begin
      r_state <= StInitRst;
      r_step  <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_data  <= '0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_is_ir <= 1'b0;
      r_host  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      r_is_ir <= w_is_ir_nxt;
      r_host  <= w_host_nxt;
    end
  end

  // Each branch on w_drive ends the current tck bit and sets up tms/tdi for the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    w_tms_nxt   = r_tms;
    w_tdi_nxt   = r_tdi;
    w_is_ir_nxt = r_is_ir;
    w_host_nxt  = r_host;
    w_accept    = 1'b0;

    unique case (r_state)
      StInitRst: begin
        if (w_drive) begin
          if (r_step == RST_LAST) begin
            w_state_nxt = r_host ? StDone : StIdle;
            w_tms_nxt   = 1'b0;
            w_host_nxt  = 1'b0;
          end else begin
            w_step_nxt = r_step + 3'd1;
            w_tms_nxt  = (r_step + 3'd1) < RST_LAST;
          end
        end
      end

      StIdle, StDone: begin
        if (r_state == StDone) begin
          w_state_nxt = StIdle;
        end
        if (cmd_if.cmd_valid && w_ready) begin
          w_accept   = 1'b1;
          w_step_nxt = '0;
          w_cnt_nxt  = '0;
          w_tdi_nxt  = 1'b0;
          w_host_nxt = 1'b0;
          unique case (w_op)
            OP_RST: begin
              w_state_nxt = StInitRst;
              w_tms_nxt   = 1'b1;
              w_host_nxt  = 1'b1;
            end
            OP_IR, OP_DR: begin
              w_state_nxt = StPre;
              w_tms_nxt   = 1'b1;
              w_is_ir_nxt = (w_op == OP_IR);
              w_last_nxt  = w_scan_last;
              w_data_nxt  = cmd_if.cmd_data;
            end
            OP_IDLE: begin
              w_state_nxt = (cmd_if.cmd_len == '0) ? StDone : StRun;
              w_tms_nxt   = 1'b0;
              w_last_nxt  = cmd_if.cmd_len - LEN_W'(1);
            end
          endcase
        end
      end

      StPre: begin
        if (w_drive) begin
          if (r_step == w_pre_last) begin
            w_state_nxt = StShift;
            w_cnt_nxt   = '0;
            w_tms_nxt   = (r_last == '0);
            w_tdi_nxt   = r_data[0];
          end else begin
            w_step_nxt = r_step + 3'd1;
            w_tms_nxt  = (r_step + 3'd1) < w_pre_ones;
          end
        end
      end

      StShift: begin
        if (w_drive) begin
          if (r_cnt == r_last) begin
            w_state_nxt = StPost;
            w_step_nxt  = '0;
            w_tms_nxt   = 1'b1;
            w_tdi_nxt   = 1'b0;
          end else begin
            w_cnt_nxt  = r_cnt + LEN_W'(1);
            w_tms_nxt  = (r_cnt + LEN_W'(1)) == r_last;
            w_data_nxt = r_data >> 1;
            w_tdi_nxt  = r_data[1];
          end
        end
      end

      StPost: begin
        if (w_drive) begin
          w_tms_nxt = 1'b0;
          if (r_step == 3'd0) begin
            w_step_nxt = 3'd1;
          end else begin
            w_state_nxt = StDone;
          end
        end
      end

      StRun: begin
        if (w_drive) begin
          if (r_cnt == r_last) begin
            w_state_nxt = StDone;
          end else begin
            w_cnt_nxt = r_cnt + LEN_W'(1);
          end
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge tclk) begin
    if (trst) begin
      r_rsp <= '0;
    end else if (w_accept) begin
      r_rsp <= '0;
    end else if (w_sample && (r_state == StShift)) begin
      r_rsp[r_cnt[IDX_W-1:0]] <= tdo_i;
    end
  end

  // The TAP moves on the rising tck, using the tms value driven for that bit.
  always_ff @(posedge tclk) begin
    if (trst) begin
      r_tap_state <= TapTlr;
    end else if (w_sample) begin
      r_tap_state <= tap_next(r_tap_state, r_tms);
    end
  end

  assign tms_o            = r_tms;
  assign tdi_o            = r_tdi;
  assign cmd_if.cmd_ready = w_ready;
  assign cmd_if.busy      = ~w_ready;
  assign cmd_if.rsp_valid = (r_state == StDone);
  assign cmd_if.rsp_data  = r_rsp;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a behavioural TAP (IR 4 bits, DR 32 bits) on the pins.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  logic tclk = 1'b0;
  logic trst = 1'b1;
  logic tck_o, tms_o, tdi_o;
  logic tdo_i = 1'b0;

  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tclk   (tclk),
    .trst   (trst),
    .cmd_if (bus),
    .tck_o  (tck_o),
    .tms_o  (tms_o),
    .tdi_o  (tdi_o),
    .tdo_i  (tdo_i)
  );

  always #5 tclk = ~tclk;

  int total = 0;
  int bad   = 0;

  // Behavioural TAP
  tap_state_e  m_state  = TapTlr;
  logic [31:0] m_dr     = '0;
  logic [31:0] dr_cap   = 32'h0000_003C;
  logic [31:0] dr_upd   = '0;
  logic [3:0]  m_ir     = '0;
  logic [3:0]  ir_upd   = '0;
  int          tck_cnt  = 0;
  int          rsp_cnt  = 0;
  logic [63:0] tms_hist = '0;

  function automatic tap_state_e model_next(input tap_state_e s, input logic tms);
    case (s)
      TapTlr:     return tms ? TapTlr : TapRti;
      TapRti:     return tms ? TapSelDr : TapRti;
      TapSelDr:   return tms ? TapSelIr : TapCapDr;
      TapCapDr:   return tms ? TapExit1Dr : TapShiftDr;
      TapShiftDr: return tms ? TapExit1Dr : TapShiftDr;
      TapExit1Dr: return tms ? TapUpdDr : TapPauseDr;
      TapPauseDr: return tms ? TapExit2Dr : TapPauseDr;
      TapExit2Dr: return tms ? TapUpdDr : TapShiftDr;
      TapUpdDr:   return tms ? TapSelDr : TapRti;
      TapSelIr:   return tms ? TapTlr : TapCapIr;
      TapCapIr:   return tms ? TapExit1Ir : TapShiftIr;
      TapShiftIr: return tms ? TapExit1Ir : TapShiftIr;
      TapExit1Ir: return tms ? TapUpdIr : TapPauseIr;
      TapPauseIr: return tms ? TapExit2Ir : TapPauseIr;
      TapExit2Ir: return tms ? TapUpdIr : TapShiftIr;
      default:    return tms ? TapSelDr : TapRti;
    endcase
  endfunction

  always @(posedge tck_o) begin
    tck_cnt  <= tck_cnt + 1;
    tms_hist <= {tms_hist[62:0], tms_o};
    case (m_state)
      TapCapDr:   m_dr <= dr_cap;
      TapShiftDr: m_dr <= {tdi_o, m_dr[31:1]};
      TapUpdDr:   dr_upd <= m_dr;
      TapCapIr:   m_ir <= 4'b0001;
      TapShiftIr: m_ir <= {tdi_o, m_ir[3:1]};
      TapUpdIr:   ir_upd <= m_ir;
      default: ;
    endcase
    m_state <= model_next(m_state, tms_o);
  end

  always @(negedge tck_o) begin
    if (m_state == TapShiftDr)      tdo_i <= m_dr[0];
    else if (m_state == TapShiftIr) tdo_i <= m_ir[0];
    else                            tdo_i <= 1'b0;
  end

  always @(posedge tclk) begin
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Issue one command from the ready state; lat = tclk edges from acceptance to rsp_valid.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output int lat, output logic [31:0] rsp);
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    rsp = bus.rsp_data;
    tick();
  endtask

  initial begin
    int          n, lat, tc0, r0, early;
    logic [31:0] rsp;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) tick();

    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_tck", tck_o, 0);
    check("rst_tms", tms_o, 1);
    check("rst_tdi", tdi_o, 0);

    // Post-reset walk to Run-Test/Idle
    trst = 1'b0;
    tc0  = tck_cnt;
    wait_ready(n);
    check("init_ready_edge", n, 12);
    check("init_tck_count", tck_cnt - tc0, 6);
    check("init_tms_seq", tms_hist[5:0], 6'b111110);
    check("init_model_rti", m_state, TapRti);
    check("init_mirror_rti", dut.r_tap_state, TapRti);
    check("init_no_rsp", rsp_cnt, 0);

    // IR scan, 4 ones; TAP captures 0001
    tc0 = tck_cnt;
    run_cmd(OP_IR, 6'd4, 32'h0000_000F, lat, rsp);
    check("ir_latency", lat, 20);
    check("ir_tck_count", tck_cnt - tc0, 10);
    check("ir_tms_seq", tms_hist[9:0], 10'b1100000110);
    check("ir_tap_ir", ir_upd, 4'hF);
    check("ir_rsp", rsp, 32'h0000_0001);
    check("ir_mirror_rti", dut.r_tap_state, TapRti);

    // DR scan 8 bits
    dr_cap = 32'h0000_003C;
    tc0    = tck_cnt;
    run_cmd(OP_DR, 6'd8, 32'h0000_00A5, lat, rsp);
    check("dr8_latency", lat, 26);
    check("dr8_tck_count", tck_cnt - tc0, 13);
    check("dr8_tms_seq", tms_hist[12:0], 13'b1000000000110);
    check("dr8_rsp", rsp, 32'h0000_003C);
    check("dr8_tdi_bits", dr_upd[31:24], 8'hA5);
    check("dr8_tdi_idle", tdi_o, 0);

    // Idle runs
    tc0 = tck_cnt;
    run_cmd(OP_IDLE, 6'd0, 32'hFFFF_FFFF, lat, rsp);
    check("idle0_latency", lat, 0);
    check("idle0_no_tck", tck_cnt - tc0, 0);
    tc0 = tck_cnt;
    run_cmd(OP_IDLE, 6'd3, 32'h0, lat, rsp);
    check("idle3_latency", lat, 6);
    check("idle3_tck_count", tck_cnt - tc0, 3);
    check("idle3_tms_seq", tms_hist[2:0], 3'b000);
    check("idle3_rsp", rsp, 32'h0);

    // Host TAP reset
    tc0 = tck_cnt;
    run_cmd(OP_RST, 6'd0, 32'h0, lat, rsp);
    check("tapreset_latency", lat, 12);
    check("tapreset_tck_count", tck_cnt - tc0, 6);
    check("tapreset_tms_seq", tms_hist[5:0], 6'b111110);
    check("tapreset_rsp", rsp, 32'h0);

    // Abort during the 4th shift bit of a 16-bit DR scan (tck high)
    bus.cmd_op    = OP_DR;
    bus.cmd_len   = 6'd16;
    bus.cmd_data  = 32'h0000_FFFF;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (13) tick();
    check("abort_tck_before", tck_o, 1);
    r0   = rsp_cnt;
    trst = 1'b1;
    tick();
    check("abort_tck", tck_o, 0);
    check("abort_tms", tms_o, 1);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy", bus.busy, 1);
    tick();
    trst = 1'b0;
    tc0  = tck_cnt;
    wait_ready(n);
    check("abort_reinit_edge", n, 12);
    check("abort_reinit_tck", tck_cnt - tc0, 6);
    check("abort_reinit_tms", tms_hist[5:0], 6'b111110);
    check("abort_no_rsp", rsp_cnt - r0, 0);
    check("abort_model_rti", m_state, TapRti);
    run_cmd(OP_DR, 6'd8, 32'h0000_00A5, lat, rsp);
    check("abort_next_rsp", rsp, 32'h0000_003C);

    // Second command held on cmd_valid while busy
    bus.cmd_op    = OP_IDLE;
    bus.cmd_len   = 6'd3;
    bus.cmd_data  = 32'h0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_op   = OP_DR;
    bus.cmd_len  = 6'd0;
    bus.cmd_data = 32'h0000_0001;
    dr_cap       = 32'hDEAD_BEEF;
    n     = 0;
    early = 0;
    while (!bus.rsp_valid && n < 100) begin
      if (bus.cmd_ready) early++;
      tick();
      n++;
    end
    check("hold_first_latency", n, 6);
    check("hold_not_ready_early", early, 0);
    check("hold_ready_with_rsp", bus.cmd_ready, 1);
    tc0 = tck_cnt;
    tick();
    bus.cmd_valid = 1'b0;
    check("hold_second_accepted", bus.cmd_ready, 0);
    check("hold_rsp_one_cycle", bus.rsp_valid, 0);
    lat = 0;
    while (!bus.rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    rsp = bus.rsp_data;
    tick();
    check("dr0_latency", lat, 12);
    check("dr0_tck_count", tck_cnt - tc0, 6);
    check("dr0_tms_seq", tms_hist[5:0], 6'b100110);
    check("dr0_rsp", rsp, 32'h0000_0001);
    check("dr0_tdi_bit", dr_upd[31], 1);

    // Oversized DR scan clamps to 32 bits
    tc0 = tck_cnt;
    run_cmd(OP_DR, 6'd40, 32'h1234_5678, lat, rsp);
    check("dr40_latency", lat, 74);
    check("dr40_tck_count", tck_cnt - tc0, 37);
    check("dr40_rsp", rsp, 32'hDEAD_BEEF);
    check("dr40_tdi_bits", dr_upd, 32'h1234_5678);
    check("dr40_mirror_rti", dut.r_tap_state, TapRti);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
